decoder_256bit_seq: RTL and testbench
=====================================

DECODER_256BIT_SEQ -- requirements
Module: decoder_256bit_seq

Interface
REQ-001 SHALL have parameter: IDXW, default 8, index width; output width is 2**IDXW; all values in this document assume IDXW=8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts beat this cycle.
REQ-006 SHALL have port: in_idx  input  8  bit index to decode.
REQ-007 SHALL have port: in_en  input  1  index valid flag (the encoder's valid); 0 = beat contributes no bit.
REQ-008 SHALL have port: in_mode  input  1  0 = single (one output per beat), 1 = accumulate (OR beats until in_last).
REQ-009 SHALL have port: in_last  input  1  closes an accumulate group; ignored in single mode.
REQ-010 SHALL have port: out_valid  output  1  output beat valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts output beat.
REQ-012 SHALL have port: out_vec  output  256  decoded vector.
REQ-013 SHALL have port: out_any  output  1  1 when out_vec is nonzero.
REQ-014 SHALL have port: out_cnt  output  9  number of distinct bits set in out_vec (0..256).

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, combinational from out_valid/out_ready only).
REQ-016 SHALL decode in_idx to one-hot: bit in_idx set iff in_en=1; in_en=0 yields all-zero contribution.
REQ-017 SHALL have group FSM states IDLE (accumulator empty) and ACCUM (group open).
REQ-018 IDLE, accepted beat, in_mode=0: SHALL load output register with decoded beat; out_valid=1 next cycle (latency 1); stay IDLE.
REQ-019 IDLE, accepted beat, in_mode=1, in_last=0: SHALL load accumulator with decoded beat, go ACCUM; no output.
REQ-020 IDLE, accepted beat, in_mode=1, in_last=1: SHALL behave as single-beat group, output next cycle, stay IDLE.
REQ-021 ACCUM, accepted beat: SHALL OR decoded beat into accumulator; in_mode is ignored while in ACCUM (group mode latched at first beat).
REQ-022 ACCUM, accepted beat with in_last=1: SHALL load output register with accumulator OR decoded beat, clear accumulator, go IDLE, out_valid=1 next cycle.
REQ-023 out_cnt SHALL increment only when an accepted in_en=1 beat sets a bit not already set; duplicate indices SHALL NOT increment; value for a single beat is in_en.
REQ-024 out_any SHALL equal (out_cnt != 0) and be registered with out_vec.
REQ-025 out_vec, out_any, out_cnt SHALL hold stable while out_valid && !out_ready.
REQ-026 Simultaneous output handshake and input accept SHALL replace the output register in the same cycle with no bubble (full throughput, one beat per cycle).
REQ-027 out_valid SHALL clear on out_ready when no new output is loaded that cycle.
REQ-028 Index 255 and index 0 SHALL map to out_vec[255] and out_vec[0]; no wrap beyond 255.

Reset
REQ-029 rst=1 SHALL immediately force out_valid=0, out_vec=0, out_any=0, out_cnt=0, accumulator=0, FSM=IDLE, independent of clk.
REQ-030 rst asserted mid-group SHALL discard the partial group; first beat after release starts a new group.
REQ-031 in_ready SHALL be 1 during and after reset (out_valid=0).

Verification
REQ-032 single mode, out_ready=1, beats idx 0,1,2,255 en=1 on consecutive cycles -> out_vec = 1<<0, 1<<1, 1<<2, 1<<255 on cycles 1..4 after first accept, out_cnt=1, out_any=1 each.
REQ-033 single mode, idx=5 en=0 -> out_vec=0, out_any=0, out_cnt=0, out_valid=1 for one beat.
REQ-034 accumulate, beats idx 3,7,3,200(last) -> one output only: bits 3,7,200 set, out_cnt=3; no out_valid before last accept.
REQ-035 out_ready=0 for 5 cycles with output pending -> out_vec stable, in_ready=0, no beat lost; release -> next beat accepted same cycle.
REQ-036 rst pulsed (async, mid-cycle) after idx 10,11 of an open group -> out_valid=0 at once; then idx 12(last) -> out_vec has only bit 12, out_cnt=1.
REQ-037 loopback: priority encoder output fed through this block in single mode, 256 random one-hot inputs -> out_vec equals original one-hot each beat.

Source files
------------

// File: rtl/decoder_256bit_seq.sv
// Streaming index-to-one-hot decoder with optional multi-beat OR accumulation.
// One output register; out_cnt reports distinct bits set, out_any flags non-empty output.
module decoder_256bit_seq #(
  parameter  int unsigned IDXW = 8,
  localparam int unsigned W    = 2**IDXW,
  localparam int unsigned CW   = IDXW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IDXW-1:0] in_idx,
  input  logic            in_en,
  input  logic            in_mode,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_vec,
  output logic            out_any,
  output logic [CW-1:0]   out_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state;
  logic [W-1:0]  acc_vec;
  logic [CW-1:0] acc_cnt;

  logic          accept;
  logic          closes;
  logic          fresh;
  logic [W-1:0]  dec;
  logic [W-1:0]  base_vec;
  logic [CW-1:0] base_cnt;
  logic [W-1:0]  merged_vec;
  logic [CW-1:0] merged_cnt;

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  // Merge the decoded beat into the open group (or an empty base in IDLE).
  always_comb begin
    accept = in_valid && in_ready;
    dec    = '0;
    if (in_en) dec[in_idx] = 1'b1;
    base_vec   = (state == ACCUM) ? acc_vec : '0;
    base_cnt   = (state == ACCUM) ? acc_cnt : '0;
    fresh      = in_en && !base_vec[in_idx];
    merged_vec = base_vec | dec;
    merged_cnt = base_cnt + CW'(fresh);
    closes     = (state == IDLE) ? (!in_mode || in_last) : in_last;
  end

  // Group FSM, accumulator and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_vec   <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_any   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (closes) begin
          out_valid <= 1'b1;
          out_vec   <= merged_vec;
          out_cnt   <= merged_cnt;
          out_any   <= (merged_cnt != '0);
          acc_vec   <= '0;
          acc_cnt   <= '0;
          state     <= IDLE;
        end else begin
          acc_vec <= merged_vec;
          acc_cnt <= merged_cnt;
          state   <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_256bit_seq.sv
// Randomized scoreboard bench for decoder_256bit_seq: driver feeds a set-based
// group model that queues expected outputs; a negedge monitor pops and compares.
module tb_decoder_256bit_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_idx;
  logic         in_en;
  logic         in_mode;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_vec;
  logic         out_any;
  logic [8:0]   out_cnt;

  decoder_256bit_seq #(.IDXW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_en(in_en), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_any(out_any), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] vec;
    logic [8:0]   cnt;
    logic         any;
  } exp_t;

  exp_t         q[$];
  int           checks   = 0;
  int           failures = 0;
  bit           m_open   = 0;
  logic [255:0] m_acc    = '0;
  bit           rdy_force = 0;
  bit           rdy_val   = 1;
  int           waited;

  // Downstream back-pressure: random unless a test pins it.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [255:0] v);
    exp_t e;
    e.vec = v;
    e.cnt = 9'($countones(v));
    e.any = (v != '0);
    q.push_back(e);
  endtask

  // Group semantics: mode latched at first beat; last closes; set union of indices.
  task automatic model_beat(input logic [7:0] idx, input bit en, input bit mode, input bit last,
                            input bit use_ovr, input logic [255:0] ovr);
    logic [255:0] c;
    c = '0;
    if (en) c[idx] = 1'b1;
    if (!m_open) begin
      if (!mode || last) push_exp(use_ovr ? ovr : c);
      else begin
        m_open = 1;
        m_acc  = c;
      end
    end else begin
      m_acc = m_acc | c;
      if (last) begin
        push_exp(m_acc);
        m_open = 0;
        m_acc  = '0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] idx, input bit en, input bit mode, input bit last,
                      input bit use_ovr, input logic [255:0] ovr);
    in_valid = 1; in_idx = idx; in_en = en; in_mode = mode; in_last = last;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        $display("FAIL accept_timeout actual=%0d expected=<=50", waited);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "input never accepted");
      end
      @(posedge clk); #1;
    end
    model_beat(idx, en, mode, last, use_ovr, ovr);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic beat(input logic [7:0] idx, input bit en, input bit mode, input bit last);
    send(idx, en, mode, last, 1'b0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 256'(q.size() != 0 || out_valid), '0);
  endtask

  // Monitor: every output handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%h cnt=%0d expected=none", out_vec, out_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_vec !== e.vec || out_cnt !== e.cnt || out_any !== e.any) begin
          failures++;
          $display("FAIL output actual=%h cnt=%0d any=%0d expected=%h cnt=%0d any=%0d",
                   out_vec, out_cnt, out_any, e.vec, e.cnt, e.any);
        end
      end
    end
  end

  initial begin
    logic [255:0] snap;
    logic [255:0] oh;
    logic [7:0]   pe;
    in_valid = 0; in_idx = 0; in_en = 0; in_mode = 0; in_last = 0;
    rst = 1;
    #1;
    check("reset_out_valid", 256'(out_valid), '0);
    check("reset_out_vec", out_vec, '0);
    check("reset_out_cnt_any", 256'({out_cnt, out_any}), '0);
    check("reset_in_ready", 256'(in_ready), 256'(1));
    #20; rst = 0;
    @(posedge clk); #1;

    // Back-to-back single beats at full throughput, including both index extremes.
    rdy_force = 1; rdy_val = 1;
    @(posedge clk); #1;
    begin
      logic [7:0] ids [4];
      ids = '{8'd0, 8'd1, 8'd2, 8'd255};
      foreach (ids[i]) begin
        beat(ids[i], 1, 0, 0);
        check("full_rate_wait", 256'(waited), '0);
      end
    end
    beat(8'd5, 0, 0, 0);
    drain();

    // Accumulate with a duplicate; second beat's mode bit must be ignored.
    beat(8'd3, 1, 1, 0);
    beat(8'd7, 1, 0, 0);
    beat(8'd3, 1, 1, 0);
    check("no_output_mid_group", 256'(out_valid), '0);
    beat(8'd200, 1, 1, 1);
    drain();

    // Stall: output held five cycles, input blocked, then accepted on release.
    rdy_val = 0;
    @(posedge clk); #1;
    beat(8'd77, 1, 0, 0);
    snap = out_vec;
    fork
      beat(8'd78, 1, 0, 0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_vec", out_vec, snap);
          check("stall_in_ready", 256'({out_valid, in_ready}), 256'(2'b10));
        end
        rdy_val = 1;
        @(negedge clk);
        check("release_in_ready", 256'(in_ready), 256'(1));
      end
    join
    drain();

    // Async reset inside an open group discards it.
    beat(8'd10, 1, 1, 0);
    beat(8'd11, 1, 1, 0);
    #1; rst = 1;
    #1;
    check("midreset_out_valid", 256'(out_valid), '0);
    check("midreset_out_vec", out_vec, '0);
    check("midreset_in_ready", 256'(in_ready), 256'(1));
    m_open = 0; m_acc = '0; q.delete();
    #1; rst = 0;
    @(posedge clk); #1;
    beat(8'd12, 1, 1, 1);
    drain();

    // Loopback through a priority encoder of random one-hot vectors.
    rdy_force = 0;
    for (int n = 0; n < 256; n++) begin
      oh = '0;
      oh[$urandom_range(0, 255)] = 1'b1;
      pe = '0;
      for (int b = 0; b < 256; b++) if (oh[b]) pe = 8'(b);
      send(pe, 1, 0, 0, 1'b1, oh);
    end
    drain();

    // Random mix of modes, enables, group lengths and idle gaps.
    for (int n = 0; n < 400; n++) begin
      beat(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    if (m_open) beat(8'd0, 0, 1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
